mem_port_arbiter: RTL and testbench

Arbiter and sequencer for the core's single-ported unified instruction/data memory. It shares one memory port between the fetch stage and the memory stage, which issues the decoder's load/store traffic. It runs a request/acknowledge handshake with variable-latency memory and produces the fetch and memory-stage stall signals. Data accesses normally win arbitration, and a starvation counter guarantees fetch forward progress.

---
 rtl/mem_port_arbiter.sv | 128 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and the memory stage: data wins arbitration,
// a streak counter bounds how long fetch can be starved, and fetch aborts are absorbed.
module mem_port_arbiter #(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   input  logic              if_abort,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_ready,
   input  logic              dm_req,
   input  logic              dm_we,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [DATA_W-1:0] dm_wdata,
   output logic [DATA_W-1:0] dm_rdata,
   output logic              dm_ready,
   output logic              stall_if,
   output logic              stall_mem,
   output logic              mem_valid,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack
);

   localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

   typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_DM} arbStateT;

   arbStateT         state, stateNext;
   logic [CNT_W-1:0] streak;
   logic             abortPend;
   logic             ifElig, dmElig, grantIf, grantDm;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= stateNext;
   end

   // A side whose ready is pulsing is finishing, so it cannot be re-granted this cycle.
   always_comb begin
      ifElig    = if_req & ~if_ready & ~if_abort;
      dmElig    = dm_req & ~dm_ready;
      grantIf   = 1'b0;
      grantDm   = 1'b0;
      stateNext = state;
      case (state)
         IDLE: begin
            grantIf = ifElig & (~dmElig | (streak == LIMIT));
            grantDm = dmElig & ~grantIf;
            if (grantIf)      stateNext = BUSY_IF;
            else if (grantDm) stateNext = BUSY_DM;
         end
         BUSY_IF, BUSY_DM: if (mem_ack) stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   always_comb begin
      stall_if  = if_req & ~if_ready & ~if_abort;
      stall_mem = dm_req & ~dm_ready;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_valid <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         if_ready  <= 1'b0;
         dm_ready  <= 1'b0;
         if_rdata  <= '0;
         dm_rdata  <= '0;
         abortPend <= 1'b0;
      end else begin
         if_ready <= 1'b0;
         dm_ready <= 1'b0;
         case (state)
            IDLE: begin
               if (grantIf) begin
                  mem_valid <= 1'b1;
                  mem_we    <= 1'b0;
                  mem_addr  <= if_addr;
               end else if (grantDm) begin
                  mem_valid <= 1'b1;
                  mem_we    <= dm_we;
                  mem_addr  <= dm_addr;
                  mem_wdata <= dm_wdata;
               end
            end
            BUSY_IF: begin
               // An abort arriving with the ack still discards the returning word.
               if (mem_ack) begin
                  mem_valid <= 1'b0;
                  abortPend <= 1'b0;
                  if (!(abortPend | if_abort)) begin
                     if_ready <= 1'b1;
                     if_rdata <= mem_rdata;
                  end
               end else if (if_abort) begin
                  abortPend <= 1'b1;
               end
            end
            BUSY_DM: begin
               if (mem_ack) begin
                  mem_valid <= 1'b0;
                  dm_ready  <= 1'b1;
                  if (!mem_we) dm_rdata <= mem_rdata;
               end
            end
            default: mem_valid <= 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                           streak <= '0;
      else if (!if_req || grantIf)          streak <= '0;
      else if (grantDm && streak != LIMIT)  streak <= streak + CNT_W'(1);
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized and directed checks of mem_port_arbiter against a transaction-level model
// that tracks the outstanding memory access and the arbitration rules.
module tb_mem_port_arbiter;

   localparam int LIMIT = 4;

   logic        clk, rst_n;
   logic        if_req, if_abort, if_ready;
   logic [31:0] if_addr, if_rdata;
   logic        dm_req, dm_we, dm_ready;
   logic [31:0] dm_addr, dm_wdata, dm_rdata;
   logic        stall_if, stall_mem;
   logic        mem_valid, mem_we, mem_ack;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(LIMIT)) dut (
      .clk(clk), .rst_n(rst_n),
      .if_req(if_req), .if_addr(if_addr), .if_abort(if_abort),
      .if_rdata(if_rdata), .if_ready(if_ready),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_rdata(dm_rdata), .dm_ready(dm_ready),
      .stall_if(stall_if), .stall_mem(stall_mem),
      .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit          isFetch;
      bit          we;
      logic [31:0] addr;
      logic [31:0] wdata;
      bit          aborted;
   } txnT;

   txnT         inflight[$];
   int          streakM;
   logic        expIfReady, expDmReady, expWe;
   logic [31:0] expIfRdata, expDmRdata, expAddr, expWdata;
   string       grantLog;

   int          checks = 0;
   int          failures = 0;
   int          memWait = 0;
   int          forceWait = 0;
   bit          spurious = 0;
   bit          useFixed = 1;
   logic [31:0] fixedRdata = '0;
   bit          ifDone, dmDone;

   task automatic chk1(string nm, logic act, logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at %0t: actual=%b required=%b", nm, $time, act, exp);
      end
   endtask

   task automatic chk32(string nm, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at %0t: actual=%h required=%h", nm, $time, act, exp);
      end
   endtask

   task automatic modelReset();
      inflight.delete();
      streakM    = 0;
      expIfReady = 1'b0;
      expDmReady = 1'b0;
      expWe      = 1'b0;
      expIfRdata = '0;
      expDmRdata = '0;
      expAddr    = '0;
      expWdata   = '0;
      memWait    = 0;
   endtask

   task automatic checkAll();
      chk1 ("mem_valid", mem_valid, inflight.size() != 0);
      chk1 ("mem_we",    mem_we,    expWe);
      chk32("mem_addr",  mem_addr,  expAddr);
      chk32("mem_wdata", mem_wdata, expWdata);
      chk1 ("if_ready",  if_ready,  expIfReady);
      chk1 ("dm_ready",  dm_ready,  expDmReady);
      chk32("if_rdata",  if_rdata,  expIfRdata);
      chk32("dm_rdata",  dm_rdata,  expDmRdata);
      chk1 ("stall_if",  stall_if,  if_req && !expIfReady && !if_abort);
      chk1 ("stall_mem", stall_mem, dm_req && !expDmReady);
   endtask

   // One clock of the reference: at most one access outstanding, retired by mem_ack.
   task automatic modelStep();
      txnT t;
      bit  rdyI = 0, rdyD = 0, ifE, dmE, pickIf = 0, pickDm = 0;
      if (inflight.size() != 0) begin
         t = inflight[0];
         if (t.isFetch && if_abort) t.aborted = 1;
         if (mem_ack) begin
            void'(inflight.pop_front());
            if (t.isFetch) begin
               if (!t.aborted) begin rdyI = 1; expIfRdata = mem_rdata; end
            end else begin
               rdyD = 1;
               if (!t.we) expDmRdata = mem_rdata;
            end
         end else begin
            inflight[0] = t;
         end
      end else begin
         dmE    = dm_req && !expDmReady;
         ifE    = if_req && !expIfReady && !if_abort;
         pickIf = ifE && (!dmE || streakM == LIMIT);
         pickDm = dmE && !pickIf;
         if (pickIf) begin
            t = '{isFetch: 1, we: 0, addr: if_addr, wdata: expWdata, aborted: 0};
            expWe = 1'b0; expAddr = if_addr;
            grantLog = {grantLog, "I"};
         end else if (pickDm) begin
            t = '{isFetch: 0, we: dm_we, addr: dm_addr, wdata: dm_wdata, aborted: 0};
            expWe = dm_we; expAddr = dm_addr; expWdata = dm_wdata;
            grantLog = {grantLog, "D"};
         end
         if (pickIf || pickDm) begin
            inflight.push_back(t);
            memWait = (forceWait >= 0) ? forceWait : int'($urandom_range(0, 3));
         end
      end
      if (!if_req || pickIf)             streakM = 0;
      else if (pickDm && streakM < LIMIT) streakM++;
      expIfReady = rdyI;
      expDmReady = rdyD;
   endtask

   task automatic settle();
      if (inflight.size() != 0) begin
         if (memWait == 0) mem_ack = 1'b1;
         else begin mem_ack = 1'b0; memWait--; end
      end else begin
         mem_ack = spurious && ($urandom_range(0, 7) == 0);
      end
      mem_rdata = useFixed ? fixedRdata : $urandom;
      #1;
      checkAll();
   endtask

   task automatic advance();
      ifDone = if_req && (expIfReady || if_abort);
      dmDone = dm_req && expDmReady;
      @(posedge clk);
      modelStep();
      @(negedge clk);
   endtask

   task automatic step();
      settle();
      advance();
   endtask

   task automatic zeroInputs();
      if_req = 0; if_abort = 0; if_addr = '0;
      dm_req = 0; dm_we = 0; dm_addr = '0; dm_wdata = '0;
      mem_ack = 0; mem_rdata = '0;
   endtask

   // Called just after settle(); asserts reset between clock edges.
   task automatic applyReset();
      #2;
      rst_n = 1'b0;
      #1;
      zeroInputs();
      chk1 ("rst mem_valid", mem_valid, 1'b0);
      chk1 ("rst mem_we",    mem_we,    1'b0);
      chk1 ("rst if_ready",  if_ready,  1'b0);
      chk1 ("rst dm_ready",  dm_ready,  1'b0);
      chk32("rst mem_addr",  mem_addr,  32'h0);
      chk32("rst mem_wdata", mem_wdata, 32'h0);
      chk32("rst if_rdata",  if_rdata,  32'h0);
      chk32("rst dm_rdata",  dm_rdata,  32'h0);
      modelReset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic randomDrive();
      if (!if_req || ifDone) begin
         if_req  = ($urandom_range(0, 2) != 0);
         if_addr = $urandom & 32'hFFFF_FFFC;
      end
      if_abort = if_req ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 19) == 0);
      if (!dm_req || dmDone) begin
         dm_req   = ($urandom_range(0, 3) != 0);
         dm_we    = 1'($urandom_range(0, 1));
         dm_addr  = $urandom & 32'hFFFF_FFFC;
         dm_wdata = $urandom;
      end
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      zeroInputs();
      modelReset();
      grantLog = "";
      repeat (2) @(negedge clk);
      #1;
      checkAll();
      chk1("reset mem_valid", mem_valid, 1'b0);
      rst_n = 1'b1;
      @(negedge clk);

      // Single fetch with zero-wait memory
      if_req = 1; if_addr = 32'h40; forceWait = 0; fixedRdata = 32'h0050_0093;
      settle(); chk1("sf c0 stall_if", stall_if, 1'b1); chk1("sf c0 mem_valid", mem_valid, 1'b0); advance();
      settle(); chk1("sf c1 mem_valid", mem_valid, 1'b1); chk1("sf c1 stall_if", stall_if, 1'b1);
      chk32("sf c1 mem_addr", mem_addr, 32'h40); advance();
      settle(); chk1("sf c2 if_ready", if_ready, 1'b1); chk32("sf c2 if_rdata", if_rdata, 32'h0050_0093);
      chk1("sf c2 mem_valid", mem_valid, 1'b0); advance();
      if_req = 0; step();

      // Collision: data first, fetch granted while dm_ready pulses
      if_req = 1; if_addr = 32'h80; dm_req = 1; dm_we = 0; dm_addr = 32'h100; fixedRdata = 32'h1234_5678;
      step();
      settle(); chk32("col mem_addr dm", mem_addr, 32'h100); chk1("col mem_valid", mem_valid, 1'b1); advance();
      settle(); chk1("col dm_ready", dm_ready, 1'b1); chk32("col dm_rdata", dm_rdata, 32'h1234_5678); advance();
      dm_req = 0;
      settle(); chk32("col mem_addr if", mem_addr, 32'h80); chk1("col mem_we", mem_we, 1'b0); advance();
      settle(); chk1("col if_ready", if_ready, 1'b1); advance();
      if_req = 0; step();

      // Store with three-cycle memory wait
      dm_req = 1; dm_we = 1; dm_addr = 32'h200; dm_wdata = 32'hDEAD_BEEF; forceWait = 2; fixedRdata = 32'hCAFE_F00D;
      step();
      for (int c = 1; c <= 3; c++) begin
         settle();
         chk1 ("st mem_valid", mem_valid, 1'b1);
         chk1 ("st mem_we",    mem_we,    1'b1);
         chk32("st mem_addr",  mem_addr,  32'h200);
         chk32("st mem_wdata", mem_wdata, 32'hDEAD_BEEF);
         advance();
      end
      settle(); chk1("st dm_ready", dm_ready, 1'b1); chk32("st dm_rdata", dm_rdata, 32'h1234_5678); advance();
      dm_req = 0; dm_we = 0; step();

      // Abort during a fetch, memory acks in cycle 2
      if_req = 1; if_addr = 32'h300; forceWait = 1; fixedRdata = 32'h0BAD_F00D;
      step();
      if_abort = 1; settle(); chk1("ab c1 stall_if", stall_if, 1'b0); advance();
      if_abort = 0; if_req = 0; step();
      dm_req = 1; dm_we = 0; dm_addr = 32'h304; forceWait = 0;
      settle(); chk1("ab c3 if_ready", if_ready, 1'b0); chk1("ab c3 mem_valid", mem_valid, 1'b0);
      chk32("ab c3 if_rdata", if_rdata, 32'h1234_5678); advance();
      settle(); chk1("ab c4 mem_valid", mem_valid, 1'b1); chk32("ab c4 mem_addr", mem_addr, 32'h304); advance();
      step(); step();
      dm_req = 0; step();

      // Starvation: fetch blocked in each dm_ready cycle so both sides compete afterwards
      grantLog = "";
      if_req = 1; if_addr = 32'h400; dm_req = 1; dm_we = 0; dm_addr = 32'h500; forceWait = 0;
      for (int i = 0; i < 100 && grantLog.len() < 10; i++) begin
         if_abort = expDmReady;
         step();
      end
      if_abort = 0;
      checks++;
      if (grantLog != "DDDDIDDDDI") begin
         failures++;
         $display("FAIL starve order: actual=%s required=DDDDIDDDDI", grantLog);
      end
      dm_req = 0;
      settle(); chk32("starve if mem_addr", mem_addr, 32'h400); advance();
      settle(); chk1("starve if_ready", if_ready, 1'b1); advance();
      if_req = 0; step();

      // Reset during BUSY_DM
      dm_req = 1; dm_we = 0; dm_addr = 32'h600; forceWait = 5;
      step();
      settle(); chk1("rm mem_valid", mem_valid, 1'b1);
      applyReset();
      for (int i = 0; i < 3; i++) begin
         settle(); chk1("rm no dm_ready", dm_ready, 1'b0); advance();
      end

      // Randomized traffic with spurious acks and occasional reset
      forceWait = -1; spurious = 1; useFixed = 0;
      ifDone = 0; dmDone = 0;
      for (int i = 0; i < 3000; i++) begin
         randomDrive();
         settle();
         if ($urandom_range(0, 499) == 0) applyReset();
         else                             advance();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
